// File: rtl/m_pcpi_arbiter_pkg.sv
// Shared types and defaults for the PCPI coprocessor arbiter.
package m_pcpi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam int ARB_N_REQ       = 2;
  localparam int ARB_ACK_TIMEOUT = 8;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } pcpi_op_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
  } pcpi_res_t;

  // Width of an index/counter that must hold values 0..n-1 (never zero bits).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m_pcpi_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr, wrapping.
module m_pcpi_arbiter_rr_picker
  import m_pcpi_arbiter_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ,
  parameter int PTR_W = idx_width(ARB_N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             any,
  output logic [PTR_W-1:0] gnt
);

  always_comb begin : pick
    int sum;
    any = 1'b0;
    gnt = '0;
    sum = 0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N_REQ) begin
        sum = sum - N_REQ;
      end
      if (!any && eligible[sum[PTR_W-1:0]]) begin
        any = 1'b1;
        gnt = sum[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/m_pcpi_arbiter.sv
// Shares one PCPI coprocessor between N_REQ masters: round-robin grant, latched
// operands, result routed to the winner, watchdog for instructions never acknowledged.
//
// state | meaning
// IDLE  | no transaction; grant the next eligible master if any
// ISSUE | cp_valid high with latched operands; waiting for cp_ready or watchdog abort
// RESP  | one-cycle req_ready/req_wr strobe to the granted master
module m_pcpi_arbiter
  import m_pcpi_arbiter_pkg::*;
#(
  parameter int N_REQ       = ARB_N_REQ,
  parameter int ACK_TIMEOUT = ARB_ACK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][31:0] req_insn,
  input  logic [N_REQ-1:0][31:0] req_rs1,
  input  logic [N_REQ-1:0][31:0] req_rs2,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       req_wr,
  output logic [N_REQ-1:0][31:0] req_rd,
  output logic [N_REQ-1:0]       req_wait,
  output logic                   cp_valid,
  output logic [31:0]            cp_insn,
  output logic [31:0]            cp_rs1,
  output logic [31:0]            cp_rs2,
  input  logic                   cp_ready,
  input  logic                   cp_wr,
  input  logic [31:0]            cp_rd,
  input  logic                   cp_busy
);

  localparam int PTR_W = idx_width(N_REQ);
  localparam int CNT_W = idx_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  arb_state_t       state;
  arb_state_t       state_n;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_next;
  logic [PTR_W-1:0] gnt;
  logic [N_REQ-1:0] blocked;
  logic [N_REQ-1:0] abort_mask;
  logic [N_REQ-1:0] eligible;
  logic [CNT_W-1:0] cnt;
  logic             acked;
  logic             acked_now;
  logic             timeout_hit;
  logic             pick_any;
  logic [PTR_W-1:0] pick_g;
  pcpi_op_t         op;
  pcpi_res_t        res;

  assign eligible  = req_valid & ~blocked;
  assign acked_now = acked | cp_busy;
  assign timeout_hit = (state == ISSUE) && !cp_ready && !acked_now && (cnt == CNT_LAST);
  assign rr_next   = (pick_g == PTR_LAST) ? '0 : pick_g + PTR_W'(1);

  m_pcpi_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .any      (pick_any),
    .gnt      (pick_g)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (cp_ready) begin
          state_n = RESP;
        end else if (timeout_hit) begin
          state_n = IDLE;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    abort_mask = '0;
    if (timeout_hit) begin
      abort_mask[gnt] = 1'b1;
    end
  end

  // A blocked master stays blocked only while it keeps holding the aborted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blocked <= '0;
    end else begin
      blocked <= (blocked & req_valid) | abort_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      gnt    <= '0;
      cnt    <= '0;
      acked  <= 1'b0;
      op     <= '0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt      <= pick_g;
            rr_ptr   <= rr_next;
            cnt      <= '0;
            acked    <= 1'b0;
            op.insn  <= req_insn[pick_g];
            op.rs1   <= req_rs1[pick_g];
            op.rs2   <= req_rs2[pick_g];
          end
        end
        ISSUE: begin
          if (cp_busy) begin
            acked <= 1'b1;
          end
          if (cp_ready) begin
            res.rd <= cp_rd;
            res.wr <= cp_wr;
          end else if (!acked_now && !timeout_hit) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cp_valid  = (state == ISSUE);
    cp_insn   = op.insn;
    cp_rs1    = op.rs1;
    cp_rs2    = op.rs2;
    req_ready = '0;
    req_wr    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rd[i] = res.rd;
    end
    if (state == RESP) begin
      req_ready[gnt] = 1'b1;
      req_wr[gnt]    = res.wr;
    end
    // Reset gates the wait hint too, so masters see no PCPI activity while held in reset.
    req_wait = reset ? '0 : eligible;
  end

endmodule

// File: tb/tb_m_pcpi_arbiter.sv
// Directed bench for m_pcpi_arbiter with a small M-extension coprocessor model.
module tb_m_pcpi_arbiter;

  localparam logic [31:0] I_MUL  = 32'h0200_0033;
  localparam logic [31:0] I_DIV  = 32'h0200_4033;
  localparam logic [31:0] I_DIVU = 32'h0200_5033;
  localparam logic [31:0] I_REMU = 32'h0200_7033;
  localparam logic [31:0] I_UNK  = 32'h0000_000B;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_insn;
  logic [1:0][31:0] req_rs1;
  logic [1:0][31:0] req_rs2;
  logic [1:0]       req_ready;
  logic [1:0]       req_wr;
  logic [1:0][31:0] req_rd;
  logic [1:0]       req_wait;
  logic             cp_valid;
  logic [31:0]      cp_insn;
  logic [31:0]      cp_rs1;
  logic [31:0]      cp_rs2;
  logic             cp_ready;
  logic             cp_wr;
  logic [31:0]      cp_rd;
  logic             cp_busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  m_pcpi_arbiter #(
    .N_REQ       (2),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_insn  (req_insn),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_rd    (req_rd),
    .req_wait  (req_wait),
    .cp_valid  (cp_valid),
    .cp_insn   (cp_insn),
    .cp_rs1    (cp_rs1),
    .cp_rs2    (cp_rs2),
    .cp_ready  (cp_ready),
    .cp_wr     (cp_wr),
    .cp_rd     (cp_rd),
    .cp_busy   (cp_busy)
  );

  // Coprocessor model: accepts M-extension ops only; MUL takes 3 cycles, DIV/REM 16.
  logic cp_run;
  int   cp_left;

  function automatic logic is_m(input logic [31:0] insn);
    return (insn[6:0] == 7'h33) && (insn[31:25] == 7'h01);
  endfunction

  function automatic logic [31:0] m_result(input logic [31:0] insn, input logic [31:0] a,
                                           input logic [31:0] b);
    case (insn[14:12])
      3'b000:  return a * b;
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : $unsigned($signed(a) / $signed(b));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b111:  return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cp_run   <= 1'b0;
      cp_left  <= 0;
      cp_busy  <= 1'b0;
      cp_ready <= 1'b0;
      cp_wr    <= 1'b0;
      cp_rd    <= 32'h0;
    end else begin
      cp_ready <= 1'b0;
      cp_wr    <= 1'b0;
      if (cp_run) begin
        if (cp_left == 0) begin
          cp_run   <= 1'b0;
          cp_busy  <= 1'b0;
          cp_ready <= 1'b1;
          cp_wr    <= 1'b1;
          cp_rd    <= m_result(cp_insn, cp_rs1, cp_rs2);
        end else begin
          cp_left <= cp_left - 1;
        end
      end else if (cp_valid && !cp_ready && is_m(cp_insn)) begin
        cp_run  <= 1'b1;
        cp_busy <= 1'b1;
        cp_left <= cp_insn[14] ? 16 : 3;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit m, input logic v, input logic [31:0] insn,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid[m] = v;
    req_insn[m]  = insn;
    req_rs1[m]   = a;
    req_rs2[m]   = b;
  endtask

  // Returns the first non-zero req_ready vector (zero on timeout) with its lane's rd/wr.
  task automatic wait_any(output logic [1:0] rdy, output logic [31:0] rd, output logic [1:0] wr);
    rdy = '0;
    rd  = '0;
    wr  = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        rdy = req_ready;
        rd  = req_ready[0] ? req_rd[0] : req_rd[1];
        wr  = req_wr;
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0]  rdy;
    logic [31:0] rd;
    logic [1:0]  wr;
    logic        stable;
    logic        quiet;
    logic        other;
    logic [1:0]  rdy_acc;
    logic [31:0] rd_seen;
    logic        wr_seen;
    int          cnt_v;
    int          pulses;

    reset     = 1'b1;
    req_valid = '0;
    req_insn  = '0;
    req_rs1   = '0;
    req_rs2   = '0;
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_cp_valid", cp_valid, 0);
    chk("rst_req_wait", req_wait, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cp_insn", cp_insn, 0);
    chk("rst_req_rd", req_rd[0], 0);
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;
    @(negedge clk);

    // Contention from rr_ptr=0: master0 first, then master1.
    drive(1'b0, 1'b1, I_DIVU, 100, 7);
    drive(1'b1, 1'b1, I_REMU, 100, 7);
    wait_any(rdy, rd, wr);
    chk("t2_first_ready", rdy, 2'b01);
    chk("t2_first_rd", rd, 14);
    chk("t2_first_wr", wr, 2'b01);
    req_valid[0] = 1'b0;
    wait_any(rdy, rd, wr);
    chk("t2_second_ready", rdy, 2'b10);
    chk("t2_second_rd", rd, 2);
    req_valid[1] = 1'b0;
    @(negedge clk);

    // Fairness: master0 reissues on its strobe; pending master1 goes first.
    drive(1'b0, 1'b1, I_MUL, 3, 5);
    drive(1'b1, 1'b1, I_MUL, 9, 9);
    wait_any(rdy, rd, wr);
    chk("t3_a_ready", rdy, 2'b01);
    chk("t3_a_rd", rd, 15);
    drive(1'b0, 1'b1, I_MUL, 2, 11);
    wait_any(rdy, rd, wr);
    chk("t3_b_ready", rdy, 2'b10);
    chk("t3_b_rd", rd, 81);
    req_valid[1] = 1'b0;
    wait_any(rdy, rd, wr);
    chk("t3_c_ready", rdy, 2'b01);
    chk("t3_c_rd", rd, 22);
    req_valid[0] = 1'b0;
    @(negedge clk);

    // Single MUL; operands must stay latched even if the master input changes.
    drive(1'b0, 1'b1, I_MUL, 7, 6);
    #1;
    chk("t1_cp_valid_pre", cp_valid, 0);
    @(negedge clk);
    chk("t1_cp_valid", cp_valid, 1);
    chk("t1_cp_insn", cp_insn, I_MUL);
    chk("t1_cp_rs1", cp_rs1, 7);
    chk("t1_cp_rs2", cp_rs2, 6);
    chk("t1_req_wait", req_wait, 2'b01);
    req_rs1[0] = 32'd99;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) break;
      if (cp_rs1 !== 32'd7 || cp_rs2 !== 32'd6) stable = 1'b0;
    end
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_wr", req_wr, 2'b01);
    chk("t1_rd0", req_rd[0], 42);
    chk("t1_rd1", req_rd[1], 42);
    chk("t1_cp_valid_resp", cp_valid, 0);
    chk("t1_operands_stable", stable, 1);
    req_valid[0] = 1'b0;
    @(negedge clk);

    // Unknown opcode: 8 cycles of cp_valid, abort, master1 served meanwhile.
    drive(1'b0, 1'b1, I_UNK, 1, 2);
    cnt_v   = 0;
    rdy_acc = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rdy_acc = rdy_acc | req_ready;
      if (cp_valid) begin
        cnt_v++;
        if (cnt_v == 3) drive(1'b1, 1'b1, I_MUL, 4, 4);
      end else if (cnt_v > 0) begin
        break;
      end
    end
    chk("t4_issue_cycles", cnt_v, 8);
    chk("t4_no_ready", rdy_acc, 0);
    chk("t4_wait_blocked", req_wait, 2'b10);
    wait_any(rdy, rd, wr);
    chk("t4_other_ready", rdy, 2'b10);
    chk("t4_other_rd", rd, 16);
    req_valid[1] = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cp_valid || req_wait != 2'b00) quiet = 1'b0;
    end
    chk("t4_not_regranted", quiet, 1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, I_MUL, 3, 3);
    #1;
    chk("t4_unblocked_wait", req_wait, 2'b01);
    wait_any(rdy, rd, wr);
    chk("t4_unblocked_ready", rdy, 2'b01);
    chk("t4_unblocked_rd", rd, 9);
    req_valid[0] = 1'b0;
    @(negedge clk);

    // Reset in ISSUE cycle 10 of a DIVU.
    drive(1'b0, 1'b1, I_DIVU, 50, 5);
    repeat (10) @(negedge clk);
    chk("t5_in_issue", cp_valid, 1);
    reset = 1'b1;
    #1;
    chk("t5_cp_valid", cp_valid, 0);
    chk("t5_req_wait", req_wait, 0);
    chk("t5_cp_insn", cp_insn, 0);
    chk("t5_cp_rs1", cp_rs1, 0);
    chk("t5_req_rd", req_rd[0], 0);
    chk("t5_req_ready", req_ready, 0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, I_DIVU, 50, 5);
    wait_any(rdy, rd, wr);
    chk("t5_fresh_ready", rdy, 2'b01);
    chk("t5_fresh_rd", rd, 10);
    req_valid[0] = 1'b0;
    @(negedge clk);

    // Signed divide by zero from master1: all-ones, exactly one strobe.
    drive(1'b1, 1'b1, I_DIV, 5, 0);
    pulses  = 0;
    rd_seen = '0;
    wr_seen = 1'b0;
    other   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        pulses++;
        rd_seen      = req_rd[1];
        wr_seen      = req_wr[1];
        req_valid[1] = 1'b0;
      end
      if (req_ready[0]) other = 1'b1;
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_rd", rd_seen, 32'hFFFF_FFFF);
    chk("t6_wr", wr_seen, 1);
    chk("t6_no_m0_ready", other, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
